floating_addition: RTL and testbench

//  IEEE-754 binary32 adder: result = a + b.

---
 rtl/fp32_pkg.sv | 27 ++
 rtl/lzc27.sv | 12 +
 rtl/floating_addition.sv | 136 +++++++++++++
 tb/tb_floating_addition.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared binary32 layout, constants and operand classification.
// Subnormals (exp == 0) count as zero throughout the datapath.
package fp32_pkg;
    localparam int          EXP_W   = 8;
    localparam int          MAN_W   = 23;
    localparam int          BIAS    = 127;
    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

    function automatic logic is_nan(input fp32_t x);
        return (x.exp == '1) && (x.man != '0);
    endfunction

    function automatic logic is_inf(input fp32_t x);
        return (x.exp == '1) && (x.man == '0);
    endfunction

    function automatic logic is_zero(input fp32_t x);
        return x.exp == '0;
    endfunction
endpackage

// File: rtl/lzc27.sv
// Combinational leading-zero counter over a 27-bit mantissa; all-zero input gives 27.
module lzc27 (
    input  logic [26:0] value_i,
    output logic [4:0]  count_o
);
    always_comb begin
        count_o = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (value_i[i]) count_o = 5'(26 - i);
        end
    end
endmodule

// File: rtl/floating_addition.sv
// Two-stage binary32 adder: stage 1 aligns operands, stage 2 adds, normalises and
// rounds to nearest-even. Subnormal inputs and results are flushed to signed zero.
module floating_addition
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    output logic [31:0] result
);
    localparam logic signed [9:0] EXP_MAX = 10'(2 * BIAS + 1);

    fp32_t       fa, fb, big, sml;
    logic        swap;
    logic [23:0] ms24;
    logic [7:0]  ediff;
    logic [53:0] wide;

    logic        spec_p1_d, sign_p1_d, sub_p1_d;
    logic [31:0] spec_val_p1_d;
    logic [7:0]  exp_p1_d;
    logic [26:0] mb_p1_d, ms_p1_d;

    logic        vld_p1_q, spec_p1_q, sign_p1_q, sub_p1_q;
    logic [31:0] spec_val_p1_q;
    logic [7:0]  exp_p1_q;
    logic [26:0] mb_p1_q, ms_p1_q;

    logic [27:0]       sum;
    logic [4:0]        lz;
    logic [26:0]       norm;
    logic signed [9:0] exp_n, exp_r;
    logic              rnd_up;
    logic [24:0]       rmant;
    logic [22:0]       man_r;
    logic [31:0]       res_p2_d;

    logic        vld_p2_q;
    logic [31:0] res_p2_q;

    // Stage 1: unpack, order by magnitude, align the smaller operand
    always_comb begin
        fa    = a;
        fb    = b;
        swap  = {fb.exp, fb.man} > {fa.exp, fa.man};
        big   = swap ? fb : fa;
        sml   = swap ? fa : fb;
        ms24  = is_zero(sml) ? 24'h0 : {1'b1, sml.man};
        ediff = big.exp - sml.exp;
        wide  = {ms24, 3'b000, 27'h0} >> ediff;

        mb_p1_d   = {1'b1, big.man, 3'b000};
        exp_p1_d  = big.exp;
        sign_p1_d = big.sign;
        sub_p1_d  = big.sign ^ sml.sign;
        if (ediff >= 8'd27) ms_p1_d = {26'h0, |ms24};
        else                ms_p1_d = {wide[53:28], wide[27] | (|wide[26:0])};

        spec_p1_d     = 1'b1;
        spec_val_p1_d = QNAN;
        if (is_nan(fa) || is_nan(fb) || (is_inf(fa) && is_inf(fb) && (fa.sign != fb.sign)))
            spec_val_p1_d = QNAN;
        else if (is_inf(fa))
            spec_val_p1_d = a;
        else if (is_inf(fb))
            spec_val_p1_d = b;
        else if (is_zero(fa) && is_zero(fb))
            spec_val_p1_d = {fa.sign & fb.sign, 31'h0};
        else begin
            spec_p1_d     = 1'b0;
            spec_val_p1_d = '0;
        end
    end

    lzc27 u_lzc (
        .value_i (sum[26:0]),
        .count_o (lz)
    );

    // Stage 2: effective add/subtract, normalise, round, pack
    always_comb begin
        sum = sub_p1_q ? ({1'b0, mb_p1_q} - {1'b0, ms_p1_q})
                       : ({1'b0, mb_p1_q} + {1'b0, ms_p1_q});
        if (sum[27]) begin
            norm  = {sum[27:2], sum[1] | sum[0]};
            exp_n = $signed({2'b00, exp_p1_q}) + 10'sd1;
        end else begin
            norm  = sum[26:0] << lz;
            exp_n = $signed({2'b00, exp_p1_q}) - $signed({5'b00000, lz});
        end
        rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        rmant  = {1'b0, norm[26:3]} + {24'h0, rnd_up};
        exp_r  = rmant[24] ? exp_n + 10'sd1 : exp_n;
        man_r  = rmant[24] ? rmant[23:1] : rmant[22:0];

        if (spec_p1_q)            res_p2_d = spec_val_p1_q;
        else if (sum == 28'h0)    res_p2_d = 32'h0;
        else if (exp_r >= EXP_MAX) res_p2_d = {sign_p1_q, POS_INF[30:0]};
        else if (exp_r < 10'sd1)  res_p2_d = {sign_p1_q, 31'h0};
        else                      res_p2_d = {sign_p1_q, exp_r[7:0], man_r};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1_q      <= 1'b0;
            spec_p1_q     <= 1'b0;
            sign_p1_q     <= 1'b0;
            sub_p1_q      <= 1'b0;
            spec_val_p1_q <= '0;
            exp_p1_q      <= '0;
            mb_p1_q       <= '0;
            ms_p1_q       <= '0;
            vld_p2_q      <= 1'b0;
            res_p2_q      <= '0;
        end else begin
            vld_p1_q <= in_valid;
            vld_p2_q <= vld_p1_q;
            if (in_valid) begin
                spec_p1_q     <= spec_p1_d;
                sign_p1_q     <= sign_p1_d;
                sub_p1_q      <= sub_p1_d;
                spec_val_p1_q <= spec_val_p1_d;
                exp_p1_q      <= exp_p1_d;
                mb_p1_q       <= mb_p1_d;
                ms_p1_q       <= ms_p1_d;
            end
            if (vld_p1_q) res_p2_q <= res_p2_d;
        end
    end

    assign out_valid = vld_p2_q;
    assign result    = res_p2_q;
endmodule

// File: tb/tb_floating_addition.sv
// Bench for floating_addition: directed corner cases plus random streams checked
// against a real-arithmetic reference with explicit round-to-nearest-even.
module tb_floating_addition;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a, b;
    logic        out_valid;
    logic [31:0] result;
    int          n_cmp = 0;
    int          n_err = 0;

    floating_addition dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .result    (result)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] dir_a [17] = '{32'h3F800000, 32'h80000000, 32'h00000000, 32'h3F800000,
                                32'h3F800000, 32'h7F800000, 32'h7F7FFFFF, 32'h7FC00001,
                                32'hFF800000, 32'h3F800000, 32'h40400000, 32'h4D800000,
                                32'h80800001, 32'h3FFFFFFF, 32'h7F7FFFFF, 32'h7F800000,
                                32'hFF800000};
    logic [31:0] dir_b [17] = '{32'hBF800000, 32'h80000000, 32'h80000000, 32'h33800000,
                                32'h33800001, 32'hFF800000, 32'h7F7FFFFF, 32'h3F800000,
                                32'h3F800000, 32'h00000001, 32'hC0000000, 32'h3F800000,
                                32'h00800000, 32'h33800000, 32'h73000000, 32'h7F800000,
                                32'hFFC00000};
    logic [31:0] dir_e [17] = '{32'h00000000, 32'h80000000, 32'h00000000, 32'h3F800000,
                                32'h3F800001, 32'h7FC00000, 32'h7F800000, 32'h7FC00000,
                                32'hFF800000, 32'h3F800000, 32'h3F800000, 32'h4D800000,
                                32'h80000000, 32'h40000000, 32'h7F800000, 32'h7F800000,
                                32'h7FC00000};

    function automatic real f2r(input logic [31:0] x);
        real m;
        int  e;
        if (x[30:23] == 8'h0) return 0.0;
        m = real'({1'b1, x[22:0]});
        e = int'(x[30:23]) - 150;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return x[31] ? -m : m;
    endfunction

    // Exact double sum (operand exponents kept within 20) then one RNE rounding to fp32.
    function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y);
        real         s;
        logic [63:0] d;
        int          e;
        logic [24:0] m;
        logic [28:0] rem;
        logic        xnan, ynan, xinf, yinf;
        xnan = (x[30:23] == 8'hFF) && (x[22:0] != 0);
        ynan = (y[30:23] == 8'hFF) && (y[22:0] != 0);
        xinf = (x[30:23] == 8'hFF) && (x[22:0] == 0);
        yinf = (y[30:23] == 8'hFF) && (y[22:0] == 0);
        if (xnan || ynan || (xinf && yinf && x[31] != y[31])) return 32'h7FC00000;
        if (xinf) return x;
        if (yinf) return y;
        if (x[30:23] == 0 && y[30:23] == 0) return {x[31] & y[31], 31'h0};
        s = f2r(x) + f2r(y);
        if (s == 0.0) return 32'h0;
        d   = $realtobits(s);
        e   = int'(d[62:52]) - 1023 + 127;
        m   = {2'b01, d[51:29]};
        rem = d[28:0];
        if (rem > 29'h10000000 || (rem == 29'h10000000 && m[0])) m = m + 25'd1;
        if (m[24]) begin m = m >> 1; e++; end
        if (e >= 255) return {d[63], 8'hFF, 23'h0};
        if (e < 1) return {d[63], 31'h0};
        return {d[63], e[7:0], m[22:0]};
    endfunction

    task automatic gen_pair(output logic [31:0] x, output logic [31:0] y);
        int ea, eb;
        ea = int'($urandom_range(230, 40));
        eb = ea + int'($urandom_range(40, 0)) - 20;
        x  = {1'($urandom), 8'(ea), 23'($urandom)};
        y  = {1'($urandom), 8'(eb), 23'($urandom)};
        if ($urandom_range(7, 0) == 0) y = {~x[31], x[30:0]};
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b1; a = 32'h3F800000; b = 32'h40000000;
        repeat (3) tick();
        n_cmp++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b expected 0", out_valid);
        else ; if (out_valid !== 1'b0) n_err++;
        n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL reset_result got %h expected 00000000", result); end
        in_valid = 1'b0; rst_n = 1'b1;
        repeat (2) tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_release_valid got %b expected 0", out_valid); end
    endtask

    task automatic test_basic;
        a = 32'h3F800000; b = 32'h40000000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL latency_early got %b expected 0", out_valid); end
        tick();
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL latency_valid got %b expected 1", out_valid); end
        n_cmp++; if (result !== 32'h40400000) begin n_err++; $display("FAIL one_plus_two got %h expected 40400000", result); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bubble_valid got %b expected 0", out_valid); end
        n_cmp++; if (result !== 32'h40400000) begin n_err++; $display("FAIL result_hold got %h expected 40400000", result); end
    endtask

    task automatic test_directed;
        for (int i = 0; i < 17; i++) begin
            a = dir_a[i]; b = dir_b[i]; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            tick();
            n_cmp++;
            if (out_valid !== 1'b1 || result !== dir_e[i]) begin
                n_err++;
                $display("FAIL directed[%0d] %h+%h got v=%b %h expected v=1 %h",
                         i, dir_a[i], dir_b[i], out_valid, result, dir_e[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic        v [0:31];
        logic [31:0] e [0:31];
        logic [31:0] x, y, last;
        bit          have_last = 0;
        for (int c = 0; c < 19; c++) begin
            if (c < 17 && c != 8) begin
                gen_pair(x, y);
                a = x; b = y; in_valid = 1'b1;
                v[c] = 1'b1; e[c] = ref_add(x, y);
            end else begin
                in_valid = 1'b0; v[c] = 1'b0; e[c] = 32'h0;
            end
            tick();
            if (c >= 1) begin
                n_cmp++;
                if (out_valid !== v[c-1]) begin n_err++; $display("FAIL b2b_valid[%0d] got %b expected %b", c, out_valid, v[c-1]); end
                if (v[c-1]) begin
                    n_cmp++;
                    if (result !== e[c-1]) begin n_err++; $display("FAIL b2b_result[%0d] got %h expected %h", c, result, e[c-1]); end
                    last = e[c-1]; have_last = 1;
                end else if (have_last) begin
                    n_cmp++;
                    if (result !== last) begin n_err++; $display("FAIL b2b_hold[%0d] got %h expected %h", c, result, last); end
                end
            end
        end
    endtask

    task automatic test_reset_inflight;
        a = 32'h3F800000; b = 32'h40000000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        a = 32'h40A00000; b = 32'h3F800000; in_valid = 1'b1;
        tick();
        a = 32'h41200000; b = 32'h40000000; rst_n = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL inflight_rst_valid got %b expected 0", out_valid); end
        n_cmp++; if (result !== 32'h0) begin n_err++; $display("FAIL inflight_rst_result got %h expected 00000000", result); end
        rst_n = 1'b1; in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b0 || result !== 32'h0) begin
                n_err++;
                $display("FAIL inflight_drop[%0d] got v=%b %h expected v=0 00000000", k, out_valid, result);
            end
        end
    endtask

    task automatic test_random;
        logic        v [0:255];
        logic [31:0] e [0:255];
        logic [31:0] x, y;
        for (int c = 0; c < 202; c++) begin
            if (c < 200 && $urandom_range(3, 0) != 0) begin
                gen_pair(x, y);
                a = x; b = y; in_valid = 1'b1;
                v[c] = 1'b1; e[c] = ref_add(x, y);
            end else begin
                in_valid = 1'b0; v[c] = 1'b0; e[c] = 32'h0;
            end
            tick();
            if (c >= 1) begin
                n_cmp++;
                if (out_valid !== v[c-1]) begin n_err++; $display("FAIL rand_valid[%0d] got %b expected %b", c, out_valid, v[c-1]); end
                if (v[c-1]) begin
                    n_cmp++;
                    if (result !== e[c-1]) begin n_err++; $display("FAIL rand_result[%0d] got %h expected %h", c, result, e[c-1]); end
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = 32'h0; b = 32'h0;
        test_reset();
        test_basic();
        test_directed();
        test_back_to_back();
        test_reset_inflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
